text_console_writer: RTL and testbench
======================================

# text_console_writer

Character-stream front end for the VGA text-mode display. It accepts one 8-bit glyph/control byte at a time over a valid/ready handshake and keeps a cursor. Each byte is turned into Avalon-MM master writes into the text VRAM: 80×30 cells, two cells per 32-bit word. It sits directly upstream of the VGA text interface's Avalon slave port and handles line wrap, newline, carriage return, backspace and clear-screen, so software or the MIDI status logic can print text without computing VRAM addresses.

## Interface
Parameters:
- COLS, 80, columns per row (even)
- ROWS, 30, rows per screen
- BASE_ADDR, 12'h000, word address of cell (0,0) in VRAM
- CLEAR_ATTR, 8'h10, attribute byte used for cleared cells (fgd_idx=1, bkg_idx=0)

Ports:
- CLK  in  1  single clock for all logic
- RESET  in  1  asynchronous, active-high reset
- CHAR_VALID  in  1  input byte valid
- CHAR_READY  out  1  block can accept a byte this cycle
- CHAR_DATA  in  8  [7]=inverse bit, [6:0]=glyph code / control code
- ATTR  in  8  [7:4]=fgd palette index, [3:0]=bkg palette index; sampled with the byte
- M_WRITE  out  1  Avalon-MM write request
- M_ADDR  out  12  VRAM word address
- M_BYTE_EN  out  4  byte enables
- M_WRITEDATA  out  32  write data
- M_WAITREQUEST  in  1  slave stall; write completes when M_WRITE & !M_WAITREQUEST
- CURSOR_COL  out  7  current column
- CURSOR_ROW  out  5  current row
- BUSY  out  1  high in any state other than IDLE

## Operation
- Cell layout in a word: even column uses bits [15:8]={IV,code} and [7:0]=attr, with M_BYTE_EN=4'b0011. Odd column uses bits [31:24]={IV,code} and [23:16]=attr, with M_BYTE_EN=4'b1100. Unused bytes are driven 0.
- Cell word address = BASE_ADDR + row*(COLS/2) + (col>>1). This is 12-bit arithmetic with no overflow check.
- Clear word = {8'h20, CLEAR_ATTR, 8'h20, CLEAR_ATTR}, with M_BYTE_EN=4'hF.
- States: IDLE, WR_CHAR, CLR_ROW, CLR_SCREEN.
- IDLE: CHAR_READY=1. A byte is accepted when CHAR_VALID & CHAR_READY. Decoding of an accepted byte:
  - Control bytes are recognized only when CHAR_DATA[7]=0:
    - 0x0D (CR): col←0; stay IDLE.
    - 0x0A (LF): col←0, row←(row+1) mod ROWS; go to CLR_ROW.
    - 0x08 (BS) at col>0: col←col−1, then write a space with the sampled ATTR at the new col; go to WR_CHAR.
    - 0x08 (BS) at col=0: no change.
    - 0x0C (FF): col←0, row←0; go to CLR_SCREEN.
  - Every other byte, including any byte with bit7=1, is drawn: CHAR_DATA and ATTR are latched and the block goes to WR_CHAR.
- WR_CHAR: M_WRITE is held with stable address, data and byte enables until the cycle with !M_WAITREQUEST. On completion of a drawn glyph:
  - col<COLS−1: col+1, back to IDLE.
  - col=COLS−1: col←0, row←(row+1) mod ROWS, go to CLR_ROW.
  - A BS write completes with no cursor advance and returns to IDLE.
- CLR_ROW: issues COLS/2 clear-word writes to the current row, in ascending address order, then returns to IDLE. The cursor is unchanged.
- CLR_SCREEN: issues ROWS*COLS/2 (1200) clear-word writes from BASE_ADDR upward, then returns to IDLE.
- Every row advance, whether from LF or wrap, clears the newly entered row. There is no scrolling; row ROWS−1 wraps to row 0.

## Timing
- Reset values: CHAR_READY=0 while RESET=1; M_WRITE=0, M_ADDR=BASE_ADDR, M_BYTE_EN=0, M_WRITEDATA=0, CURSOR_COL=0, CURSOR_ROW=0, BUSY=1.
- After RESET falls, the state is CLR_SCREEN and M_WRITE rises on the first clock edge. The power-up clear is mandatory.
- Accept edge → M_WRITE high on the next cycle, so the glyph latency is 1 cycle to request.
- Throughput with M_WAITREQUEST=0 is one glyph per 2 cycles: IDLE then WR_CHAR.
- The cursor updates on the completing edge.
- CR and BS-at-col-0 consume 1 cycle, and CHAR_READY stays high.
- Clear loops with no stall advance one word per cycle: a row clear takes 40 cycles, a screen clear takes 1200.
- M_WAITREQUEST freezes the address, data, counter and state.
- Reset asserted mid-write drops M_WRITE immediately (combinationally via async clear of registered outputs) and zeroes the cursor. The clear is restarted after release.
- CHAR_VALID while BUSY is ignored and not lost: the producer holds it until CHAR_READY.

## Test plan
- Reset release with M_WAITREQUEST=0 → exactly 1200 writes, addresses 0x000..0x4AF, data 0x20102010, BE=4'hF; then CHAR_READY=1, cursor (0,0).
- Bytes 'H' (0x48) then 'i' (0x69), ATTR=0x31, at (0,0):
  - write 1: addr 0x000, BE 4'b0011, data 0x00004831.
  - write 2: addr 0x000, BE 4'b1100, data 0x69310000.
  - Cursor ends at (2,0).
- Glyph at col 79 row 29:
  - Glyph write to addr 0x4AF with BE 4'b1100.
  - Cursor moves to (0,0), followed by 40 clear writes to 0x000..0x027.
- CR, LF, BS at cursor (5,3):
  - CR → cursor (0,3), no write.
  - LF → cursor (0,4), then 40 clears to addr 0x0A0..0x0C7.
  - BS → no write, cursor stays (0,4).
- Hold M_WAITREQUEST=1 for 5 cycles during a glyph write → M_WRITE and M_ADDR stable for 6 cycles, a single completion, CHAR_READY low throughout.
- Assert RESET during CLR_SCREEN at word 300 → M_WRITE=0 immediately, cursor (0,0); after release the clear restarts at 0x000.

Source files
------------

// File: rtl/text_console_writer.sv
// Character-stream front end for the VGA text VRAM: turns glyph/control bytes into
// Avalon-MM cell writes, tracks the cursor and performs row/screen clears.
module text_console_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [11:0] BASE_ADDR  = 12'h000,
  parameter logic [7:0]  CLEAR_ATTR = 8'h10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  output logic        CHAR_READY,
  input  logic [7:0]  CHAR_DATA,
  input  logic [7:0]  ATTR,
  output logic        M_WRITE,
  output logic [11:0] M_ADDR,
  output logic [3:0]  M_BYTE_EN,
  output logic [31:0] M_WRITEDATA,
  input  logic        M_WAITREQUEST,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic        BUSY
);

  localparam logic [31:0] CLR_WORD     = {8'h20, CLEAR_ATTR, 8'h20, CLEAR_ATTR};
  localparam logic [11:0] ROW_WORDS    = 12'(COLS / 2);
  localparam logic [11:0] SCREEN_WORDS = 12'(ROWS * COLS / 2);
  localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, WR_CHAR, CLR_ROW, CLR_SCREEN} state_t;

  state_t      state_q;
  logic        wr_q;
  logic [11:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] data_q;
  logic [6:0]  col_q;
  logic [4:0]  row_q;
  logic [11:0] cnt_q;
  logic        bs_q;

  logic [6:0]  prev_col_d;
  logic [4:0]  next_row_d;
  logic [11:0] clr_last_d;

  function automatic logic [11:0] row_base(input logic [4:0] row);
    return BASE_ADDR + 12'(row) * ROW_WORDS;
  endfunction

  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return row_base(row) + 12'(col >> 1);
  endfunction

  function automatic logic [31:0] cell_data(input logic [6:0] col, input logic [7:0] code,
                                            input logic [7:0] attr);
    return col[0] ? {code, attr, 16'h0000} : {16'h0000, code, attr};
  endfunction

  function automatic logic [3:0] cell_be(input logic [6:0] col);
    return col[0] ? 4'b1100 : 4'b0011;
  endfunction

  assign prev_col_d = col_q - 7'd1;
  assign next_row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign clr_last_d = ((state_q == CLR_ROW) ? ROW_WORDS : SCREEN_WORDS) - 12'd1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // Power-up lands in CLR_SCREEN with no request yet; the first edge starts the clear.
      state_q <= CLR_SCREEN;
      wr_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      be_q    <= 4'h0;
      data_q  <= 32'h0;
      col_q   <= 7'd0;
      row_q   <= 5'd0;
      cnt_q   <= 12'd0;
      bs_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CHAR_VALID) begin
            if (!CHAR_DATA[7] && CHAR_DATA[6:0] == 7'h0D) begin
              col_q <= 7'd0;
            end else if (!CHAR_DATA[7] && CHAR_DATA[6:0] == 7'h0A) begin
              col_q   <= 7'd0;
              row_q   <= next_row_d;
              state_q <= CLR_ROW;
              wr_q    <= 1'b1;
              addr_q  <= row_base(next_row_d);
              data_q  <= CLR_WORD;
              be_q    <= 4'hF;
              cnt_q   <= 12'd0;
            end else if (!CHAR_DATA[7] && CHAR_DATA[6:0] == 7'h08) begin
              if (col_q != 7'd0) begin
                col_q   <= prev_col_d;
                state_q <= WR_CHAR;
                wr_q    <= 1'b1;
                bs_q    <= 1'b1;
                addr_q  <= cell_addr(row_q, prev_col_d);
                data_q  <= cell_data(prev_col_d, 8'h20, ATTR);
                be_q    <= cell_be(prev_col_d);
              end
            end else if (!CHAR_DATA[7] && CHAR_DATA[6:0] == 7'h0C) begin
              col_q   <= 7'd0;
              row_q   <= 5'd0;
              state_q <= CLR_SCREEN;
              wr_q    <= 1'b1;
              addr_q  <= BASE_ADDR;
              data_q  <= CLR_WORD;
              be_q    <= 4'hF;
              cnt_q   <= 12'd0;
            end else begin
              state_q <= WR_CHAR;
              wr_q    <= 1'b1;
              bs_q    <= 1'b0;
              addr_q  <= cell_addr(row_q, col_q);
              data_q  <= cell_data(col_q, CHAR_DATA, ATTR);
              be_q    <= cell_be(col_q);
            end
          end
        end
        WR_CHAR: begin
          if (!M_WAITREQUEST) begin
            wr_q    <= 1'b0;
            state_q <= IDLE;
            if (!bs_q) begin
              if (col_q == LAST_COL) begin
                // Wrapping into a new row clears it straight away.
                col_q   <= 7'd0;
                row_q   <= next_row_d;
                state_q <= CLR_ROW;
                wr_q    <= 1'b1;
                addr_q  <= row_base(next_row_d);
                data_q  <= CLR_WORD;
                be_q    <= 4'hF;
                cnt_q   <= 12'd0;
              end else begin
                col_q <= col_q + 7'd1;
              end
            end
          end
        end
        default: begin
          if (!wr_q) begin
            wr_q   <= 1'b1;
            addr_q <= BASE_ADDR;
            data_q <= CLR_WORD;
            be_q   <= 4'hF;
            cnt_q  <= 12'd0;
          end else if (!M_WAITREQUEST) begin
            if (cnt_q == clr_last_d) begin
              wr_q    <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q  <= cnt_q + 12'd1;
              addr_q <= addr_q + 12'd1;
            end
          end
        end
      endcase
    end
  end

  assign CHAR_READY  = (state_q == IDLE);
  assign BUSY        = (state_q != IDLE);
  assign M_WRITE     = wr_q;
  assign M_ADDR      = addr_q;
  assign M_BYTE_EN   = be_q;
  assign M_WRITEDATA = data_q;
  assign CURSOR_COL  = col_q;
  assign CURSOR_ROW  = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: power-up clear, glyph writes, wrap,
// control codes, wait-state stalls and reset during activity.
module tb_text_console_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CHAR_VALID;
  logic        CHAR_READY;
  logic [7:0]  CHAR_DATA;
  logic [7:0]  ATTR;
  logic        M_WRITE;
  logic [11:0] M_ADDR;
  logic [3:0]  M_BYTE_EN;
  logic [31:0] M_WRITEDATA;
  logic        M_WAITREQUEST;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic        BUSY;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] CLR = 32'h20102010;

  text_console_writer dut (
    .CLK(CLK), .RESET(RESET), .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
    .CHAR_DATA(CHAR_DATA), .ATTR(ATTR), .M_WRITE(M_WRITE), .M_ADDR(M_ADDR),
    .M_BYTE_EN(M_BYTE_EN), .M_WRITEDATA(M_WRITEDATA), .M_WAITREQUEST(M_WAITREQUEST),
    .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Present a byte and hold it until accepted; returns on the negedge after the accept edge.
  task automatic send_byte(input logic [7:0] code, input logic [7:0] attr);
    int n;
    n = 0;
    CHAR_VALID = 1'b1;
    CHAR_DATA  = code;
    ATTR       = attr;
    while (CHAR_READY !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (CHAR_READY !== 1'b1) begin
      fails++;
      $display("FAIL send_timeout code=%h ready=%b required 1", code, CHAR_READY);
    end
    @(negedge CLK);
    CHAR_VALID = 1'b0;
  endtask

  // Record clear-word writes until the block returns to IDLE.
  task automatic drain_clear(input logic [11:0] first, output int nwr, output int nbad);
    int guard;
    logic [11:0] exp_addr;
    nwr = 0;
    nbad = 0;
    guard = 0;
    while (CHAR_READY !== 1'b1 && guard < 1500) begin
      if (M_WRITE === 1'b1 && M_WAITREQUEST === 1'b0) begin
        exp_addr = first + 12'(nwr);
        if (M_ADDR !== exp_addr || M_WRITEDATA !== CLR || M_BYTE_EN !== 4'hF) nbad++;
        nwr++;
      end
      @(negedge CLK);
      guard++;
    end
  endtask

  task automatic test_reset;
    int nwr, nbad;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if (CHAR_READY !== 1'b0 || M_WRITE !== 1'b0 || M_ADDR !== 12'h000 || M_BYTE_EN !== 4'h0 ||
        M_WRITEDATA !== 32'h0 || CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL reset_values rdy=%b wr=%b addr=%h be=%h data=%h col=%0d row=%0d busy=%b required 0 0 000 0 0 0 0 1",
               CHAR_READY, M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA, CURSOR_COL, CURSOR_ROW, BUSY);
    end
    RESET = 1'b0;
    @(negedge CLK);
    tests++;
    if (M_WRITE !== 1'b1 || M_ADDR !== 12'h000) begin
      fails++;
      $display("FAIL powerup_first_write wr=%b addr=%h required 1 000", M_WRITE, M_ADDR);
    end
    drain_clear(12'h000, nwr, nbad);
    tests++;
    if (nwr != 1200 || nbad != 0) begin
      fails++;
      $display("FAIL powerup_clear writes=%0d bad=%0d required 1200 0", nwr, nbad);
    end
    tests++;
    if (CHAR_READY !== 1'b1 || CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin
      fails++;
      $display("FAIL powerup_idle rdy=%b col=%0d row=%0d required 1 0 0", CHAR_READY, CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_glyphs;
    send_byte(8'h48, 8'h31);
    tests++;
    if (M_WRITE !== 1'b1 || M_ADDR !== 12'h000 || M_BYTE_EN !== 4'b0011 ||
        M_WRITEDATA !== 32'h00004831 || CHAR_READY !== 1'b0) begin
      fails++;
      $display("FAIL glyph_H wr=%b addr=%h be=%b data=%h rdy=%b required 1 000 0011 00004831 0",
               M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA, CHAR_READY);
    end
    @(negedge CLK);
    tests++;
    if (CURSOR_COL !== 7'd1 || CURSOR_ROW !== 5'd0 || CHAR_READY !== 1'b1) begin
      fails++;
      $display("FAIL glyph_H_cursor col=%0d row=%0d rdy=%b required 1 0 1", CURSOR_COL, CURSOR_ROW, CHAR_READY);
    end
    send_byte(8'h69, 8'h31);
    tests++;
    if (M_WRITE !== 1'b1 || M_ADDR !== 12'h000 || M_BYTE_EN !== 4'b1100 || M_WRITEDATA !== 32'h69310000) begin
      fails++;
      $display("FAIL glyph_i wr=%b addr=%h be=%b data=%h required 1 000 1100 69310000",
               M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA);
    end
    @(negedge CLK);
    tests++;
    if (CURSOR_COL !== 7'd2 || CURSOR_ROW !== 5'd0) begin
      fails++;
      $display("FAIL glyph_i_cursor col=%0d row=%0d required 2 0", CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_wrap;
    int nwr, nbad;
    send_byte(8'h0D, 8'h00);
    for (int i = 0; i < 29; i++) send_byte(8'h0A, 8'h00);
    for (int i = 0; i < 79; i++) send_byte(8'h41, 8'h31);
    @(negedge CLK);
    tests++;
    if (CURSOR_COL !== 7'd79 || CURSOR_ROW !== 5'd29 || CHAR_READY !== 1'b1) begin
      fails++;
      $display("FAIL wrap_setup col=%0d row=%0d rdy=%b required 79 29 1", CURSOR_COL, CURSOR_ROW, CHAR_READY);
    end
    send_byte(8'h5A, 8'h31);
    tests++;
    if (M_WRITE !== 1'b1 || M_ADDR !== 12'h4AF || M_BYTE_EN !== 4'b1100 || M_WRITEDATA !== 32'h5A310000) begin
      fails++;
      $display("FAIL wrap_glyph wr=%b addr=%h be=%b data=%h required 1 4af 1100 5a310000",
               M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA);
    end
    @(negedge CLK);
    tests++;
    if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0 || M_WRITE !== 1'b1 || M_ADDR !== 12'h000) begin
      fails++;
      $display("FAIL wrap_cursor col=%0d row=%0d wr=%b addr=%h required 0 0 1 000",
               CURSOR_COL, CURSOR_ROW, M_WRITE, M_ADDR);
    end
    drain_clear(12'h000, nwr, nbad);
    tests++;
    if (nwr != 40 || nbad != 0) begin
      fails++;
      $display("FAIL wrap_row_clear writes=%0d bad=%0d required 40 0", nwr, nbad);
    end
  endtask

  task automatic test_ctrl;
    int nwr, nbad;
    for (int i = 0; i < 3; i++) send_byte(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'h42, 8'h31);
    @(negedge CLK);
    send_byte(8'h0D, 8'h00);
    tests++;
    if (M_WRITE !== 1'b0 || CHAR_READY !== 1'b1 || CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd3) begin
      fails++;
      $display("FAIL cr wr=%b rdy=%b col=%0d row=%0d required 0 1 0 3", M_WRITE, CHAR_READY, CURSOR_COL, CURSOR_ROW);
    end
    send_byte(8'h0A, 8'h00);
    tests++;
    if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd4 || M_WRITE !== 1'b1 || M_ADDR !== 12'h0A0) begin
      fails++;
      $display("FAIL lf col=%0d row=%0d wr=%b addr=%h required 0 4 1 0a0", CURSOR_COL, CURSOR_ROW, M_WRITE, M_ADDR);
    end
    drain_clear(12'h0A0, nwr, nbad);
    tests++;
    if (nwr != 40 || nbad != 0) begin
      fails++;
      $display("FAIL lf_row_clear writes=%0d bad=%0d required 40 0", nwr, nbad);
    end
    send_byte(8'h08, 8'h00);
    tests++;
    if (M_WRITE !== 1'b0 || CHAR_READY !== 1'b1 || CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd4) begin
      fails++;
      $display("FAIL bs_col0 wr=%b rdy=%b col=%0d row=%0d required 0 1 0 4", M_WRITE, CHAR_READY, CURSOR_COL, CURSOR_ROW);
    end
    send_byte(8'h58, 8'h31);
    @(negedge CLK);
    send_byte(8'h08, 8'h42);
    tests++;
    if (CURSOR_COL !== 7'd0 || M_WRITE !== 1'b1 || M_ADDR !== 12'h0A0 || M_BYTE_EN !== 4'b0011 ||
        M_WRITEDATA !== 32'h00002042) begin
      fails++;
      $display("FAIL bs_write col=%0d wr=%b addr=%h be=%b data=%h required 0 1 0a0 0011 00002042",
               CURSOR_COL, M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA);
    end
    @(negedge CLK);
    tests++;
    if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd4 || CHAR_READY !== 1'b1) begin
      fails++;
      $display("FAIL bs_no_advance col=%0d row=%0d rdy=%b required 0 4 1", CURSOR_COL, CURSOR_ROW, CHAR_READY);
    end
    send_byte(8'h8D, 8'h52);
    tests++;
    if (M_WRITE !== 1'b1 || M_BYTE_EN !== 4'b0011 || M_WRITEDATA !== 32'h00008D52) begin
      fails++;
      $display("FAIL inverse_cr_drawn wr=%b be=%b data=%h required 1 0011 00008d52", M_WRITE, M_BYTE_EN, M_WRITEDATA);
    end
    @(negedge CLK);
    tests++;
    if (CURSOR_COL !== 7'd1 || CURSOR_ROW !== 5'd4) begin
      fails++;
      $display("FAIL inverse_cursor col=%0d row=%0d required 1 4", CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_stall;
    int done_cnt;
    int bad;
    done_cnt = 0;
    bad = 0;
    M_WAITREQUEST = 1'b1;
    send_byte(8'h51, 8'h07);
    tests++;
    if (M_ADDR !== 12'h0A0 || M_BYTE_EN !== 4'b1100 || M_WRITEDATA !== 32'h51070000) begin
      fails++;
      $display("FAIL stall_glyph addr=%h be=%b data=%h required 0a0 1100 51070000", M_ADDR, M_BYTE_EN, M_WRITEDATA);
    end
    for (int i = 0; i < 6; i++) begin
      if (M_WRITE !== 1'b1 || M_ADDR !== 12'h0A0 || M_WRITEDATA !== 32'h51070000 || CHAR_READY !== 1'b0) bad++;
      if (i == 5) M_WAITREQUEST = 1'b0;
      if (M_WRITE === 1'b1 && M_WAITREQUEST === 1'b0) done_cnt++;
      @(negedge CLK);
    end
    if (M_WRITE === 1'b1 && M_WAITREQUEST === 1'b0) done_cnt++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold unstable_cycles=%0d required 0", bad);
    end
    tests++;
    if (done_cnt != 1 || M_WRITE !== 1'b0 || CURSOR_COL !== 7'd2 || CURSOR_ROW !== 5'd4) begin
      fails++;
      $display("FAIL stall_complete completions=%0d wr=%b col=%0d row=%0d required 1 0 2 4",
               done_cnt, M_WRITE, CURSOR_COL, CURSOR_ROW);
    end
  endtask

  task automatic test_reset_mid;
    int n, guard, nwr, nbad;
    M_WAITREQUEST = 1'b1;
    send_byte(8'h57, 8'h31);
    RESET = 1'b1;
    #1;
    tests++;
    if (M_WRITE !== 1'b0 || CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0 || CHAR_READY !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_glyph wr=%b col=%0d row=%0d rdy=%b required 0 0 0 0",
               M_WRITE, CURSOR_COL, CURSOR_ROW, CHAR_READY);
    end
    M_WAITREQUEST = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    n = 0;
    guard = 0;
    while (n < 300 && guard < 2000) begin
      if (M_WRITE === 1'b1 && M_WAITREQUEST === 1'b0) n++;
      @(negedge CLK);
      guard++;
    end
    tests++;
    if (M_WRITE !== 1'b1 || M_ADDR !== 12'h12C) begin
      fails++;
      $display("FAIL reset_mid_word300 wr=%b addr=%h required 1 12c", M_WRITE, M_ADDR);
    end
    RESET = 1'b1;
    #1;
    tests++;
    if (M_WRITE !== 1'b0 || M_ADDR !== 12'h000 || BUSY !== 1'b1 || CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin
      fails++;
      $display("FAIL reset_mid_clear wr=%b addr=%h busy=%b col=%0d row=%0d required 0 000 1 0 0",
               M_WRITE, M_ADDR, BUSY, CURSOR_COL, CURSOR_ROW);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    tests++;
    if (M_WRITE !== 1'b1 || M_ADDR !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid_restart wr=%b addr=%h required 1 000", M_WRITE, M_ADDR);
    end
    drain_clear(12'h000, nwr, nbad);
    tests++;
    if (nwr != 1200 || nbad != 0 || CHAR_READY !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_full_clear writes=%0d bad=%0d rdy=%b required 1200 0 1", nwr, nbad, CHAR_READY);
    end
  endtask

  initial begin
    RESET         = 1'b1;
    CHAR_VALID    = 1'b0;
    CHAR_DATA     = 8'h00;
    ATTR          = 8'h00;
    M_WAITREQUEST = 1'b0;
    test_reset();
    test_glyphs();
    test_wrap();
    test_ctrl();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
